sprite_fetch_sched: RTL
=======================

Name: sprite_fetch_sched

Overview:
- Parametrised sequencer that refreshes per-sprite line graphics during horizontal blanking.
- Replaces the fixed decode of pixel column into sprite index and data-valid strobes.
- Supports any sprite count, words per line, memory latency and line timing.
- Sits between the display timing generator's pixel column and the sprite manager's index and data-valid inputs. Flags lines where the fetch cannot finish before the line wraps.

Parameters:
- N_SPRITES, 16, sprite slots fetched per line; index value N_SPRITES is the null (never-shown) index.
- IDX_W, 5, width of sprite_index; must satisfy 2^IDX_W > N_SPRITES.
- WORDS, 2, graphics words per sprite line.
- WSEL_W, 1, width of word_sel; must satisfy 2^WSEL_W >= WORDS.
- MEM_LAT, 3, cycles from index presentation until the data word is valid (>= 1).
- COL_W, 12, pixel column width.
- START_COL, 704, column at which the fetch starts (visible width 640 + sort time 64).

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  asynchronous active-high reset.
- pix_col  in  COL_W  current pixel column from the timing generator; 0 marks line start.
- enable  in  1  allows fetch starts.
- sprite_index  out  IDX_W  sprite slot being fetched; N_SPRITES when idle.
- word_sel  out  WSEL_W  word within the sprite line being fetched.
- sprite_dvalid  out  WORDS  one-hot strobe; bit w = word w of sprite_index is valid this cycle.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle pulse when the last word strobe of a line has been issued.
- overrun  out  1  sticky; the line wrapped before the fetch completed.

Behaviour:
- Reset (async, rst=1): sprite_index=N_SPRITES, word_sel=0, sprite_dvalid=0, busy=0, done=0, overrun=0, state=IDLE. All outputs are registered.
- States: IDLE, FETCH, DONE.
- IDLE -> FETCH:
  - Occurs on the edge where pix_col==START_COL and enable=1.
  - On the next cycle: busy=1, sprite_index=0, word_sel=0, per-word cycle counter cnt=0.
- FETCH, per word:
  - Each word occupies exactly MEM_LAT+1 cycles.
  - sprite_index and word_sel are held stable for the whole window.
  - cnt counts 0..MEM_LAT. sprite_dvalid[word_sel]=1 only in the cycle where cnt==MEM_LAT; zero otherwise.
- Advance:
  - After the strobe cycle, word_sel increments.
  - When word_sel==WORDS-1, word_sel wraps to 0 and sprite_index increments.
- After the strobe for sprite N_SPRITES-1 and word WORDS-1:
  - Go to DONE for one cycle: done=1, busy=0, sprite_index=N_SPRITES.
  - Then return to IDLE.
- Total fetch time is N_SPRITES*WORDS*(MEM_LAT+1) cycles. With defaults: 128 cycles, first index at column 705.
- Line wrap while busy (pix_col==0 in FETCH):
  - Abort to IDLE on that edge; overrun=1 (sticky until rst).
  - sprite_index=N_SPRITES, dvalid=0, done not pulsed.
  - The partial line's graphics are undefined by design.
- Start condition while in FETCH or DONE: ignored.
- enable deasserted mid-fetch: the current line completes normally; only new starts are gated.
- At most one sprite_dvalid bit is high in any cycle. dvalid never asserts in IDLE.
- Counters never wrap past their limits. Index arithmetic uses IDX_W bits with no overflow, guaranteed by the parameter constraint.

Test Plan:
- Reset mid-fetch: assert rst at column 710 -> outputs return to sprite_index=N_SPRITES, dvalid=0, busy=0, overrun=0 immediately (async); no activity until the next column 704.
- N_SPRITES=8, WORDS=2, MEM_LAT=3, normal 800-column lines:
  - busy rises at column 705.
  - dvalid[0] at 708, dvalid[1] at 712 (index 0); index 1 at 713.
  - done pulse at column 769; overrun stays 0.
- Defaults (16 sprites, 128 cycles) with an 800-column line:
  - pix_col reaches 0 during the fetch at column 800 (index 11) -> abort, overrun=1 sticks across following lines, done never pulses.
- Enable handling:
  - enable=0 at column 704 -> no fetch that line, index stays 16.
  - enable dropped at column 720 after a start -> fetch completes, done pulses.
- WORDS=4, WSEL_W=2, MEM_LAT=1, N_SPRITES=4:
  - dvalid walks 0001, 0010, 0100, 1000 on alternate cycles per sprite; 32-cycle fetch.
  - A bench assertion checks dvalid is one-hot-or-zero every cycle.

Source files
------------

// File: rtl/sprite_fetch_sched.sv
// Sprite line-graphics fetch sequencer for horizontal blanking.
// On the start column it walks every sprite slot and every word of that
// slot's line, holding index/word stable for MEM_LAT+1 cycles and strobing
// the matching sprite_dvalid bit in the last cycle of each window.
// A line wrap while fetching aborts the sequence and sets a sticky overrun.
module sprite_fetch_sched #(
    parameter int N_SPRITES = 16,
    parameter int IDX_W     = 5,
    parameter int WORDS     = 2,
    parameter int WSEL_W    = 1,
    parameter int MEM_LAT   = 3,
    parameter int COL_W     = 12,
    parameter int START_COL = 704
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COL_W-1:0]  pix_col,
    input  logic              enable,
    output logic [IDX_W-1:0]  sprite_index,
    output logic [WSEL_W-1:0] word_sel,
    output logic [WORDS-1:0]  sprite_dvalid,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MEM_LAT);
    localparam logic [IDX_W-1:0]  IDX_NULL = IDX_W'(N_SPRITES);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_SPRITES - 1);
    localparam logic [WSEL_W-1:0] WS_LAST  = WSEL_W'(WORDS - 1);
    localparam logic [COL_W-1:0]  START    = COL_W'(START_COL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   index_reg, index_next;
    logic [WSEL_W-1:0]  word_sel_reg, word_sel_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic [WORDS-1:0]   dvalid_reg, dvalid_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               overrun_reg, overrun_next;
    logic [WORDS-1:0]   word_onehot;

    // One-hot decode of the word currently being fetched (strobe pattern).
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word_dec
        assign word_onehot[gi] = (word_sel_reg == WSEL_W'(gi));
    end

    assign cnt_inc = cnt_reg + 1'b1;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            index_reg    <= IDX_NULL;
            word_sel_reg <= '0;
            cnt_reg      <= '0;
            dvalid_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            index_reg    <= index_next;
            word_sel_reg <= word_sel_next;
            cnt_reg      <= cnt_next;
            dvalid_reg   <= dvalid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            overrun_reg  <= overrun_next;
        end
    end

    // Next-state logic: strobe is raised one edge early so the registered
    // dvalid lines up with the cycle where the counter shows MEM_LAT.
    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        word_sel_next = word_sel_reg;
        cnt_next      = cnt_reg;
        dvalid_next   = '0;
        busy_next     = 1'b0;
        done_next     = 1'b0;
        overrun_next  = overrun_reg;

        case (state_reg)
            IDLE: begin
                index_next = IDX_NULL;
                if (pix_col == START && enable) begin
                    state_next    = FETCH;
                    busy_next     = 1'b1;
                    index_next    = '0;
                    word_sel_next = '0;
                    cnt_next      = '0;
                end
            end

            FETCH: begin
                if (pix_col == '0) begin
                    // Line wrapped before the fetch finished: give up on this line.
                    state_next    = IDLE;
                    overrun_next  = 1'b1;
                    index_next    = IDX_NULL;
                    word_sel_next = '0;
                    cnt_next      = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    // Strobe cycle just shown; move on to the next word.
                    cnt_next  = '0;
                    busy_next = 1'b1;
                    if (word_sel_reg == WS_LAST) begin
                        word_sel_next = '0;
                        if (index_reg == IDX_LAST) begin
                            state_next = DONE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                            index_next = IDX_NULL;
                        end else begin
                            index_next = index_reg + 1'b1;
                        end
                    end else begin
                        word_sel_next = word_sel_reg + 1'b1;
                    end
                end else begin
                    busy_next = 1'b1;
                    cnt_next  = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        dvalid_next = word_onehot;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
                index_next = IDX_NULL;
            end

            default: begin
                state_next = IDLE;
                index_next = IDX_NULL;
            end
        endcase
    end

    assign sprite_index  = index_reg;
    assign word_sel      = word_sel_reg;
    assign sprite_dvalid = dvalid_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign overrun       = overrun_reg;

endmodule
